// File: rtl/pic_param_core_if.sv
// CPU-side handshake and EOI command bundle for pic_param_core.
// The controller core takes the slave modport; the CPU/command side takes master.
interface pic_param_core_if #(
   parameter int unsigned NUM_IRQ = 8
) ();
   localparam int unsigned ID_W = $clog2(NUM_IRQ);

   logic            inta;
   logic            eoi_valid;
   logic            eoi_specific;
   logic [ID_W-1:0] eoi_id;
   logic            int_out;
   logic            vector_valid;
   logic [7:0]      vector_out;

   modport master (
      output inta,
      output eoi_valid,
      output eoi_specific,
      output eoi_id,
      input  int_out,
      input  vector_valid,
      input  vector_out
   );

   modport slave (
      input  inta,
      input  eoi_valid,
      input  eoi_specific,
      input  eoi_id,
      output int_out,
      output vector_valid,
      output vector_out
   );
endinterface

// File: rtl/pic_param_core.sv
// 8259-style interrupt controller core: IRR/ISR, nested or rotating priority, two-pulse INTA
// handshake, specific/non-specific EOI and AEOI. Define PIC_POLL_EN to add the poll command.
module pic_param_core #(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_lines,
   input  logic               trig_level,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               rotate_en,
   input  logic               aeoi,
   input  logic [7:0]         vec_base,
`ifdef PIC_POLL_EN
   input  logic               poll_req,
   output logic [7:0]         poll_word,
`endif
   output logic [NUM_IRQ-1:0] irr_status,
   output logic [NUM_IRQ-1:0] isr_status,
   pic_param_core_if.slave    bus
);
   localparam int unsigned     ID_W    = $clog2(NUM_IRQ);
   localparam logic [ID_W:0]   NumIrqW = (ID_W + 1)'(NUM_IRQ);
   localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_IRQ - 1);

   typedef enum logic {StIdle, StWait2} state_e;

   state_e             state_q, state_d;
   logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, prev_q;
   logic [ID_W-1:0]    id_q, id_d, last_q, last_d;
   logic               spur_q, spur_d, int_out_q, int_out_d, vv_q, vv_d;
   logic [7:0]         vo_q, vo_d;
`ifdef PIC_POLL_EN
   logic [7:0]         poll_q, poll_d;
`endif

   // Distance of ch below the current highest-priority channel hi (0 = highest).
   function automatic logic [ID_W-1:0] ch_rank(input logic [ID_W-1:0] ch,
                                                input logic [ID_W-1:0] hi);
      logic [ID_W:0] r;
      r = (ch >= hi) ? {1'b0, ch} - {1'b0, hi} : {1'b0, ch} + NumIrqW - {1'b0, hi};
      return ID_W'(r);
   endfunction

   // Highest-priority set bit of vec, walking from hi; result is {found, id}.
   function automatic logic [ID_W:0] pick(input logic [NUM_IRQ-1:0] vec,
                                          input logic [ID_W-1:0]    hi);
      logic [ID_W:0] ch;
      logic [ID_W:0] res;
      res = '0;
      for (int r = NUM_IRQ - 1; r >= 0; r--) begin
         ch = {1'b0, hi} + (ID_W + 1)'(r);
         if (ch >= NumIrqW) ch = ch - NumIrqW;
         if (vec[ID_W'(ch)]) res = {1'b1, ID_W'(ch)};
      end
      return res;
   endfunction

   logic [ID_W-1:0]    hi;
   logic [ID_W:0]      isr_top, win, eoi_top;
   logic [NUM_IRQ-1:0] above, cand;

   always_comb begin
      hi      = (rotate_en && last_q != LastId) ? last_q + ID_W'(1) : '0;
      isr_top = pick(isr_q, hi);
      above   = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         above[ID_W'(i)] = !isr_top[ID_W] ||
                           (ch_rank(ID_W'(i), hi) < ch_rank(isr_top[ID_W-1:0], hi));
      end
      cand = irr_q & ~irq_mask & above;
      win  = pick(cand, hi);
   end

   logic [NUM_IRQ-1:0] new_edge, irr_clr, isr_set, isr_a;
   logic               eoi_hit;
   logic [ID_W-1:0]    eoi_ch;

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      spur_d    = spur_q;
      last_d    = last_q;
      vv_d      = 1'b0;
      vo_d      = vo_q;
      int_out_d = (state_q == StIdle) && win[ID_W];
      new_edge  = irq_lines & ~prev_q;
      irr_clr   = '0;
      isr_set   = '0;
      isr_a     = isr_q;
      eoi_hit   = 1'b0;
      eoi_ch    = '0;
      eoi_top   = '0;
`ifdef PIC_POLL_EN
      poll_d    = '0;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.inta) begin
               state_d   = StWait2;
               int_out_d = 1'b0;
               // A real acknowledge needs int_out already raised and a live winner.
               if (win[ID_W] && int_out_q) begin
                  id_d                     = win[ID_W-1:0];
                  spur_d                   = 1'b0;
                  isr_set[win[ID_W-1:0]]   = 1'b1;
                  irr_clr[win[ID_W-1:0]]   = 1'b1;
               end else begin
                  id_d   = LastId;
                  spur_d = 1'b1;
               end
            end
`ifdef PIC_POLL_EN
            else if (poll_req) begin
               int_out_d = 1'b0;
               poll_d    = {win[ID_W], 2'b00, 5'(win[ID_W-1:0])};
               if (win[ID_W]) begin
                  irr_clr[win[ID_W-1:0]] = 1'b1;
                  if (aeoi) begin
                     if (rotate_en) last_d = win[ID_W-1:0];
                  end else begin
                     isr_set[win[ID_W-1:0]] = 1'b1;
                  end
               end
            end
`endif
         end
         StWait2: begin
            if (bus.inta) begin
               state_d = StIdle;
               vv_d    = 1'b1;
               vo_d    = {vec_base[7:ID_W], id_q};
               if (aeoi && !spur_q) begin
                  isr_a[id_q] = 1'b0;
                  if (rotate_en) last_d = id_q;
               end
            end
         end
      endcase

      // EOI sees the ISR after any AEOI clear; ACK1 set is ORed in afterwards.
      if (bus.eoi_valid) begin
         if (bus.eoi_specific) begin
            if ({1'b0, bus.eoi_id} < NumIrqW && isr_a[bus.eoi_id]) begin
               eoi_hit = 1'b1;
               eoi_ch  = bus.eoi_id;
            end
         end else begin
            eoi_top = pick(isr_a, hi);
            eoi_hit = eoi_top[ID_W];
            eoi_ch  = eoi_top[ID_W-1:0];
         end
      end
      if (eoi_hit) begin
         isr_a[eoi_ch] = 1'b0;
         if (rotate_en) last_d = eoi_ch;
      end

      isr_d = isr_a | isr_set;
      irr_d = trig_level ? irq_lines : ((irr_q & ~irr_clr) | new_edge);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         irr_q     <= '0;
         isr_q     <= '0;
         prev_q    <= '0;
         id_q      <= '0;
         last_q    <= LastId;
         spur_q    <= 1'b0;
         int_out_q <= 1'b0;
         vv_q      <= 1'b0;
         vo_q      <= '0;
`ifdef PIC_POLL_EN
         poll_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         irr_q     <= irr_d;
         isr_q     <= isr_d;
         prev_q    <= irq_lines;
         id_q      <= id_d;
         last_q    <= last_d;
         spur_q    <= spur_d;
         int_out_q <= int_out_d;
         vv_q      <= vv_d;
         vo_q      <= vo_d;
`ifdef PIC_POLL_EN
         poll_q    <= poll_d;
`endif
      end
   end

   assign bus.int_out      = int_out_q;
   assign bus.vector_valid = vv_q;
   assign bus.vector_out   = vo_q;
   assign irr_status       = irr_q;
   assign isr_status       = isr_q;
`ifdef PIC_POLL_EN
   assign poll_word        = poll_q;
`endif

   // Low vector bits are replaced by the channel id.
   logic unused_vec_base;
   assign unused_vec_base = ^vec_base[ID_W-1:0];
endmodule
